// File: rtl/cs_frame_scheduler.sv
// Purpose : round-robin arbiter sharing one cs_encoder between NUM_CH channels;
//           configures the encoder per frame and routes the granted channel's stream.
// Latency : grant/config registered one cycle after pick; sample path is zero-latency pass-through.
// Backpressure: enc_s_tready is forwarded to the granted channel only; all others see ready=0.
// Ports   : clk/rst; ch_* per-channel AXIS in + ratio/seed config; enc_s_* encoder input
//           stream; enc_m_* encoder output monitor taps; enc_cfg_* encoder config;
//           grant/frame_done/frame_ch status; len_err/ratio_err sticky error flags.
// Option  : define CS_SCHED_TIMEOUT_EN to add a 16-bit stream/drain watchdog and timeout_err.
module cs_frame_scheduler #(
    parameter int NUM_CH      = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int LFSR_WIDTH  = 32,
    parameter int INPUT_SIZE  = 1024,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CH*2*DATA_WIDTH-1:0]   ch_tdata,
    input  logic [NUM_CH-1:0]                ch_tvalid,
    input  logic [NUM_CH-1:0]                ch_tlast,
    output logic [NUM_CH-1:0]                ch_tready,
    input  logic [NUM_CH*4-1:0]              ch_ratio,
    input  logic [NUM_CH*LFSR_WIDTH-1:0]     ch_seed,
    output logic [2*DATA_WIDTH-1:0]          enc_s_tdata,
    output logic                             enc_s_tvalid,
    output logic                             enc_s_tlast,
    input  logic                             enc_s_tready,
    input  logic                             enc_m_tvalid,
    input  logic                             enc_m_tlast,
    input  logic                             enc_m_tready,
    output logic [3:0]                       enc_cfg_ratio,
    output logic [LFSR_WIDTH-1:0]            enc_cfg_seed,
    output logic                             enc_cfg_enable,
    input  logic                             enc_busy,
    output logic [NUM_CH-1:0]                grant,
    output logic                             frame_done,
    output logic [$clog2(NUM_CH)-1:0]        frame_ch,
    output logic                             len_err,
    output logic                             ratio_err
`ifdef CS_SCHED_TIMEOUT_EN
    ,
    output logic                             timeout_err
`endif
);

    localparam int SEL_W  = $clog2(NUM_CH);
    localparam int BEAT_W = 2 * DATA_WIDTH;
    localparam int CNT_W  = $clog2(INPUT_SIZE) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [SEL_W-1:0]         sel_q, sel_d;
    logic [SEL_W-1:0]         rr_q, rr_d;
    logic [NUM_CH-1:0]        grant_q, grant_d;
    logic [3:0]               ratio_q, ratio_d;
    logic [LFSR_WIDTH-1:0]    seed_q, seed_d;
    logic [CNT_W-1:0]         beat_cnt_q, beat_cnt_d;
    logic [FRAME_CNT_W-1:0]   frame_cnt_q [NUM_CH];
    logic [FRAME_CNT_W-1:0]   frame_cnt_d [NUM_CH];
    logic                     frame_done_q, frame_done_d;
    logic [SEL_W-1:0]         frame_ch_q, frame_ch_d;
    logic                     len_err_q, len_err_d;
    logic                     ratio_err_q, ratio_err_d;
`ifdef CS_SCHED_TIMEOUT_EN
    logic [15:0]              wd_q, wd_d;
    logic                     tout_q, tout_d;
    logic                     timeout_err_q, timeout_err_d;
`endif

    // Arbitration: first requester at or above rr_q, wrapping.
    logic             pick_vld;
    logic [SEL_W-1:0] pick_idx;

    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!pick_vld && ch_tvalid[(int'(rr_q) + i) % NUM_CH]) begin
                pick_vld = 1'b1;
                pick_idx = SEL_W'((int'(rr_q) + i) % NUM_CH);
            end
        end
    end

    // Config values for the candidate channel.
    logic [3:0]            pick_ratio;
    logic [LFSR_WIDTH-1:0] pick_seed_raw;
    logic                  pick_ratio_ok;

    assign pick_ratio    = ch_ratio[pick_idx*4 +: 4];
    assign pick_ratio_ok = (pick_ratio >= 4'd2) && (pick_ratio <= 4'd10);
    assign pick_seed_raw = ch_seed[pick_idx*LFSR_WIDTH +: LFSR_WIDTH]
                         ^ LFSR_WIDTH'(frame_cnt_q[pick_idx]);

    // Stream routing for the granted channel.
    logic                 in_stream;
    logic                 sel_tvalid;
    logic                 sel_tlast;
    logic                 in_hs;
    logic                 out_hs;
    logic [CNT_W-1:0]     beat_inc;

    assign in_stream  = (state_q == S_STREAM);
    assign sel_tvalid = ch_tvalid[sel_q];
    assign sel_tlast  = ch_tlast[sel_q];

    assign enc_s_tdata  = in_stream ? ch_tdata[sel_q*BEAT_W +: BEAT_W] : '0;
    assign enc_s_tvalid = in_stream & sel_tvalid;
    assign enc_s_tlast  = in_stream & sel_tlast;
    assign ch_tready    = in_stream ? (NUM_CH'(enc_s_tready) << sel_q) : '0;

    assign in_hs    = enc_s_tvalid & enc_s_tready;
    assign out_hs   = enc_m_tvalid & enc_m_tready;
    assign beat_inc = beat_cnt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        rr_d         = rr_q;
        grant_d      = grant_q;
        ratio_d      = ratio_q;
        seed_d       = seed_q;
        beat_cnt_d   = beat_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;
        frame_ch_d   = frame_ch_q;
        len_err_d    = len_err_q;
        ratio_err_d  = ratio_err_q;
`ifdef CS_SCHED_TIMEOUT_EN
        wd_d          = wd_q;
        tout_d        = tout_q;
        timeout_err_d = timeout_err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (!enc_busy && pick_vld) begin
                    sel_d      = pick_idx;
                    grant_d    = NUM_CH'(1) << pick_idx;
                    beat_cnt_d = '0;
                    if (pick_ratio_ok) begin
                        ratio_d = pick_ratio;
                    end else begin
                        ratio_d     = 4'd4;
                        ratio_err_d = 1'b1;
                    end
                    // An all-zero seed would lock the encoder LFSR.
                    seed_d = (pick_seed_raw == '0) ? LFSR_WIDTH'(1) : pick_seed_raw;
                    state_d = S_CFG;
                end
            end
            S_CFG: begin
`ifdef CS_SCHED_TIMEOUT_EN
                wd_d = '0;
`endif
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (in_hs) begin
                    beat_cnt_d = beat_inc;
                    if (sel_tlast || (beat_inc == CNT_W'(INPUT_SIZE))) begin
                        if (beat_inc != CNT_W'(INPUT_SIZE)) begin
                            len_err_d = 1'b1;
                        end
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (out_hs && enc_m_tlast) begin
                    frame_done_d = 1'b1;
                    frame_ch_d   = sel_q;
                    state_d      = S_DONE;
                end
            end
            S_DONE: begin
`ifdef CS_SCHED_TIMEOUT_EN
                // A timed-out frame does not advance the channel's seed sequence.
                if (!tout_q) begin
                    frame_cnt_d[sel_q] = frame_cnt_q[sel_q] + 1'b1;
                end
                tout_d = 1'b0;
`else
                frame_cnt_d[sel_q] = frame_cnt_q[sel_q] + 1'b1;
`endif
                rr_d    = (int'(sel_q) == NUM_CH - 1) ? '0 : sel_q + 1'b1;
                grant_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef CS_SCHED_TIMEOUT_EN
        // Watchdog: any handshake restarts it; saturation aborts the frame.
        if ((state_q == S_STREAM) || (state_q == S_DRAIN)) begin
            if (in_hs || out_hs) begin
                wd_d = '0;
            end else if (wd_q == 16'hFFFF) begin
                timeout_err_d = 1'b1;
                tout_d        = 1'b1;
                frame_done_d  = 1'b1;
                frame_ch_d    = sel_q;
                state_d       = S_DONE;
            end else begin
                wd_d = wd_q + 16'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sel_q        <= '0;
            rr_q         <= '0;
            grant_q      <= '0;
            ratio_q      <= '0;
            seed_q       <= '0;
            beat_cnt_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                frame_cnt_q[i] <= '0;
            end
            frame_done_q <= 1'b0;
            frame_ch_q   <= '0;
            len_err_q    <= 1'b0;
            ratio_err_q  <= 1'b0;
`ifdef CS_SCHED_TIMEOUT_EN
            wd_q          <= '0;
            tout_q        <= 1'b0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            rr_q         <= rr_d;
            grant_q      <= grant_d;
            ratio_q      <= ratio_d;
            seed_q       <= seed_d;
            beat_cnt_q   <= beat_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_done_d;
            frame_ch_q   <= frame_ch_d;
            len_err_q    <= len_err_d;
            ratio_err_q  <= ratio_err_d;
`ifdef CS_SCHED_TIMEOUT_EN
            wd_q          <= wd_d;
            tout_q        <= tout_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign enc_cfg_ratio  = ratio_q;
    assign enc_cfg_seed   = seed_q;
    assign enc_cfg_enable = (state_q == S_CFG) || (state_q == S_STREAM) || (state_q == S_DRAIN);
    assign grant          = grant_q;
    assign frame_done     = frame_done_q;
    assign frame_ch       = frame_ch_q;
    assign len_err        = len_err_q;
    assign ratio_err      = ratio_err_q;
`ifdef CS_SCHED_TIMEOUT_EN
    assign timeout_err    = timeout_err_q;
`endif

endmodule

// File: tb/tb_cs_frame_scheduler.sv
module tb_cs_frame_scheduler;

    localparam int NUM_CH = 4;
    localparam int DW     = 16;
    localparam int LW     = 32;
    localparam int ISZ    = 1024;
    localparam int FCW    = 16;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_CH*2*DW-1:0]    ch_tdata;
    logic [NUM_CH-1:0]         ch_tvalid;
    logic [NUM_CH-1:0]         ch_tlast;
    logic [NUM_CH-1:0]         ch_tready;
    logic [NUM_CH*4-1:0]       ch_ratio;
    logic [NUM_CH*LW-1:0]      ch_seed;
    logic [2*DW-1:0]           enc_s_tdata;
    logic                      enc_s_tvalid;
    logic                      enc_s_tlast;
    logic                      enc_s_tready;
    logic                      enc_m_tvalid;
    logic                      enc_m_tlast;
    logic                      enc_m_tready;
    logic [3:0]                enc_cfg_ratio;
    logic [LW-1:0]             enc_cfg_seed;
    logic                      enc_cfg_enable;
    logic                      enc_busy;
    logic [NUM_CH-1:0]         grant;
    logic                      frame_done;
    logic [1:0]                frame_ch;
    logic                      len_err;
    logic                      ratio_err;
`ifdef CS_SCHED_TIMEOUT_EN
    logic                      timeout_err;
`endif

    always #5 clk = ~clk;

    cs_frame_scheduler #(
        .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .LFSR_WIDTH(LW),
        .INPUT_SIZE(ISZ), .FRAME_CNT_W(FCW)
    ) dut (
        .clk(clk), .rst(rst),
        .ch_tdata(ch_tdata), .ch_tvalid(ch_tvalid), .ch_tlast(ch_tlast),
        .ch_tready(ch_tready), .ch_ratio(ch_ratio), .ch_seed(ch_seed),
        .enc_s_tdata(enc_s_tdata), .enc_s_tvalid(enc_s_tvalid),
        .enc_s_tlast(enc_s_tlast), .enc_s_tready(enc_s_tready),
        .enc_m_tvalid(enc_m_tvalid), .enc_m_tlast(enc_m_tlast),
        .enc_m_tready(enc_m_tready), .enc_cfg_ratio(enc_cfg_ratio),
        .enc_cfg_seed(enc_cfg_seed), .enc_cfg_enable(enc_cfg_enable),
        .enc_busy(enc_busy), .grant(grant), .frame_done(frame_done),
        .frame_ch(frame_ch), .len_err(len_err), .ratio_err(ratio_err)
`ifdef CS_SCHED_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Channel sources: test sets request totals, length and stall point.
    int src_req   [NUM_CH] = '{0, 0, 0, 0};
    int src_len   [NUM_CH] = '{ISZ, ISZ, ISZ, ISZ};
    int src_stall [NUM_CH] = '{1 << 30, 1 << 30, 1 << 30, 1 << 30};
    int src_done  [NUM_CH] = '{0, 0, 0, 0};
    int src_beat  [NUM_CH] = '{0, 0, 0, 0};

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            ch_tvalid[k]          = (src_done[k] < src_req[k]) && (src_beat[k] < src_stall[k]);
            ch_tlast[k]           = (src_beat[k] == src_len[k] - 1);
            ch_tdata[k*32 +: 32]  = 32'((k << 16) + src_beat[k]);
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) src_beat[k] <= 0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (ch_tvalid[k] && ch_tready[k]) begin
                    if (ch_tlast[k]) begin
                        src_beat[k] <= 0;
                        src_done[k] <= src_done[k] + 1;
                    end else begin
                        src_beat[k] <= src_beat[k] + 1;
                    end
                end
            end
        end
    end

    // Encoder stand-in: one output per 'ratio' inputs, final output with tlast.
    int enc_in_cnt;
    int ratio_eff;
    assign ratio_eff = (enc_cfg_ratio == 4'd0) ? 1 : int'(enc_cfg_ratio);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            enc_m_tvalid <= 1'b0;
            enc_m_tlast  <= 1'b0;
            enc_busy     <= 1'b0;
            enc_in_cnt   <= 0;
        end else begin
            enc_m_tvalid <= 1'b0;
            enc_m_tlast  <= 1'b0;
            if (enc_s_tvalid && enc_s_tready) begin
                enc_busy <= 1'b1;
                if (enc_s_tlast) begin
                    enc_in_cnt   <= 0;
                    enc_m_tvalid <= 1'b1;
                    enc_m_tlast  <= 1'b1;
                end else begin
                    enc_in_cnt <= enc_in_cnt + 1;
                    if ((enc_in_cnt + 1) % ratio_eff == 0) enc_m_tvalid <= 1'b1;
                end
            end else if (!enc_cfg_enable) begin
                enc_busy <= 1'b0;
            end
            if (enc_m_tvalid && enc_m_tlast) enc_busy <= 1'b0;
        end
    end

    // Monitors.
    int                out_cnt  = 0;
    int                done_cnt = 0;
    int                viol     = 0;
    logic [NUM_CH-1:0] grant_prev = '0;
    logic [NUM_CH-1:0] glog [$];

    always @(posedge clk) begin
        if (enc_m_tvalid && enc_m_tready) out_cnt <= out_cnt + 1;
        if (frame_done) done_cnt <= done_cnt + 1;
        if (grant != '0 && grant_prev == '0) glog.push_back(grant);
        grant_prev <= grant;
        if ($countones(grant) > 1 || (ch_tready & ~grant) != '0) viol <= viol + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (grant != '0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_done(input int budget, output bit ok, output int cycles);
        ok = 1'b0;
        cycles = 0;
        for (int i = 0; i < budget; i++) begin
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if (grant !== '0 || ch_tready !== '0 || enc_s_tvalid !== 1'b0 || enc_cfg_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: grant=%b tready=%b svalid=%b en=%b required all 0",
                     grant, ch_tready, enc_s_tvalid, enc_cfg_enable);
        end
        checks++;
        if (enc_cfg_ratio !== 4'd0 || enc_cfg_seed !== '0 || frame_done !== 1'b0 ||
            frame_ch !== 2'd0 || len_err !== 1'b0 || ratio_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_stat: ratio=%0h seed=%0h done=%b ch=%0d lerr=%b rerr=%b required all 0",
                     enc_cfg_ratio, enc_cfg_seed, frame_done, frame_ch, len_err, ratio_err);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        bit ok;
        int cyc, o0, d0;
        ch_ratio[3:0]  = 4'd4;
        ch_seed[31:0]  = 32'hDEADBEEF;
        src_len[0]     = ISZ;
        o0 = out_cnt;
        d0 = done_cnt;
        src_req[0] = src_done[0] + 1;
        wait_grant(ok);
        checks++;
        if (!ok || grant !== 4'b0001) begin
            errors++;
            $display("FAIL single_grant: got %b required 0001", grant);
        end
        checks++;
        if (enc_cfg_seed !== 32'hDEADBEEF || enc_cfg_ratio !== 4'd4 || enc_cfg_enable !== 1'b1) begin
            errors++;
            $display("FAIL single_cfg: seed=%h ratio=%0d en=%b required deadbeef 4 1",
                     enc_cfg_seed, enc_cfg_ratio, enc_cfg_enable);
        end
        wait_done(3000, ok, cyc);
        checks++;
        if (!ok || frame_ch !== 2'd0) begin
            errors++;
            $display("FAIL single_done: seen=%b ch=%0d required 1 0", ok, frame_ch);
        end
        tick();
        checks++;
        if (out_cnt - o0 != 256 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL single_counts: outputs=%0d dones=%0d required 256 1", out_cnt - o0, done_cnt - d0);
        end
        checks++;
        if (len_err !== 1'b0 || ratio_err !== 1'b0 || grant !== '0) begin
            errors++;
            $display("FAIL single_err: lerr=%b rerr=%b grant=%b required 0 0 0", len_err, ratio_err, grant);
        end
        src_req[0] = src_done[0] + 1;
        wait_grant(ok);
        checks++;
        if (!ok || enc_cfg_seed !== 32'hDEADBEEE) begin
            errors++;
            $display("FAIL single_seed2: got %h required deadbeee", enc_cfg_seed);
        end
        wait_done(3000, ok, cyc);
        tick();
    endtask

    task automatic test_round_robin();
        int g0, v0;
        bit all_done;
        logic [NUM_CH-1:0] exp_g;
        do_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            ch_ratio[k*4 +: 4] = 4'd4;
            ch_seed[k*32 +: 32] = 32'(32'h1000 + k);
            src_len[k] = ISZ;
        end
        g0 = glog.size();
        v0 = viol;
        for (int k = 0; k < NUM_CH; k++) src_req[k] = src_done[k] + 3;
        all_done = 1'b0;
        for (int i = 0; i < 16000 && !all_done; i++) begin
            tick();
            all_done = (grant == '0);
            for (int k = 0; k < NUM_CH; k++) if (src_done[k] < src_req[k]) all_done = 1'b0;
        end
        checks++;
        if (!all_done || glog.size() - g0 != 12) begin
            errors++;
            $display("FAIL rr_count: finished=%b grants=%0d required 1 12", all_done, glog.size() - g0);
        end
        for (int i = 0; i < 12; i++) begin
            exp_g = 4'b0001 << (i % 4);
            checks++;
            if (g0 + i >= glog.size() || glog[g0 + i] !== exp_g) begin
                errors++;
                $display("FAIL rr_order[%0d]: got %b required %b", i,
                         (g0 + i < glog.size()) ? glog[g0 + i] : 4'b0, exp_g);
            end
        end
        checks++;
        if (viol != v0) begin
            errors++;
            $display("FAIL rr_exclusive: violations=%0d required 0", viol - v0);
        end
    endtask

    task automatic test_bad_ratio();
        bit ok;
        int cyc;
        ch_ratio[11:8] = 4'd12;
        src_req[2] = src_done[2] + 1;
        wait_grant(ok);
        checks++;
        if (!ok || grant !== 4'b0100 || enc_cfg_ratio !== 4'd4 || ratio_err !== 1'b1) begin
            errors++;
            $display("FAIL ratio_clamp: grant=%b ratio=%0d rerr=%b required 0100 4 1",
                     grant, enc_cfg_ratio, ratio_err);
        end
        wait_done(3000, ok, cyc);
        checks++;
        if (!ok || frame_ch !== 2'd2) begin
            errors++;
            $display("FAIL ratio_done: seen=%b ch=%0d required 1 2", ok, frame_ch);
        end
        tick();
        checks++;
        if (len_err !== 1'b0) begin
            errors++;
            $display("FAIL ratio_lenerr: got %b required 0", len_err);
        end
    endtask

    task automatic test_short_frame();
        bit ok;
        int cyc, tgt;
        ch_ratio[7:4] = 4'd4;
        src_len[1] = 1000;
        tgt = src_done[1] + 1;
        src_req[1] = tgt;
        for (int i = 0; i < 2000 && src_done[1] < tgt; i++) tick();
        checks++;
        if (src_done[1] != tgt || len_err !== 1'b1 || enc_s_tvalid !== 1'b0 ||
            ch_tready !== '0 || enc_cfg_enable !== 1'b1 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL short_drain: done=%0d lerr=%b sv=%b rdy=%b en=%b fd=%b required %0d 1 0 0 1 0",
                     src_done[1], len_err, enc_s_tvalid, ch_tready, enc_cfg_enable, frame_done, tgt);
        end
        wait_done(10, ok, cyc);
        checks++;
        if (!ok || frame_ch !== 2'd1) begin
            errors++;
            $display("FAIL short_done: seen=%b ch=%0d required 1 1", ok, frame_ch);
        end
        tick();
        src_len[1] = ISZ;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int cyc;
        ch_seed[31:0] = 32'h1234_5678;
        src_req[3] = src_done[3] + 1;
        wait_grant(ok);
        checks++;
        if (!ok || grant !== 4'b1000) begin
            errors++;
            $display("FAIL rst_pregrant: got %b required 1000", grant);
        end
        for (int i = 0; i < 1000 && src_beat[3] < 500; i++) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (grant !== '0 || ch_tready !== '0 || enc_s_tvalid !== 1'b0 || enc_cfg_enable !== 1'b0 ||
            enc_cfg_seed !== '0 || enc_cfg_ratio !== 4'd0 || len_err !== 1'b0 || ratio_err !== 1'b0 ||
            frame_done !== 1'b0 || frame_ch !== 2'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: grant=%b rdy=%b sv=%b en=%b seed=%h ratio=%0d lerr=%b rerr=%b fd=%b ch=%0d required all 0",
                     grant, ch_tready, enc_s_tvalid, enc_cfg_enable, enc_cfg_seed, enc_cfg_ratio,
                     len_err, ratio_err, frame_done, frame_ch);
        end
        tick();
        tick();
        rst = 1'b0;
        src_req[0] = src_done[0] + 1;
        wait_grant(ok);
        checks++;
        if (!ok || grant !== 4'b0001 || enc_cfg_seed !== 32'h1234_5678) begin
            errors++;
            $display("FAIL rst_restart: grant=%b seed=%h required 0001 12345678", grant, enc_cfg_seed);
        end
        wait_done(3000, ok, cyc);
        tick();
        wait_done(3000, ok, cyc);
        checks++;
        if (!ok || frame_ch !== 2'd3) begin
            errors++;
            $display("FAIL rst_resume: seen=%b ch=%0d required 1 3", ok, frame_ch);
        end
        tick();
    endtask

`ifdef CS_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int cyc;
        src_stall[3] = 10;
        src_req[3] = src_done[3] + 1;
        wait_grant(ok);
        wait_done(70000, ok, cyc);
        checks++;
        if (!ok || cyc < 65535 || cyc > 65600) begin
            errors++;
            $display("FAIL tout_delay: seen=%b cycles=%0d required 1 65535..65600", ok, cyc);
        end
        checks++;
        if (timeout_err !== 1'b1 || frame_ch !== 2'd3) begin
            errors++;
            $display("FAIL tout_flag: terr=%b ch=%0d required 1 3", timeout_err, frame_ch);
        end
        tick();
        tick();
        checks++;
        if (grant !== '0 || enc_cfg_enable !== 1'b0) begin
            errors++;
            $display("FAIL tout_idle: grant=%b en=%b required 0 0", grant, enc_cfg_enable);
        end
    endtask
`endif

    initial begin
        rst          = 1'b1;
        ch_ratio     = '0;
        ch_seed      = '0;
        enc_s_tready = 1'b1;
        enc_m_tready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_bad_ratio();
        test_short_frame();
        test_reset_mid();
`ifdef CS_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cs_frame_scheduler.md
Name: cs_frame_scheduler

Overview:
Round-robin scheduler that shares one cs_encoder instance between NUM_CH receive channels. It grants one channel at a time and configures the encoder for that frame (compression ratio, per-frame seed). It then routes that channel's AXI4-Stream samples into the encoder and tracks the encoder output stream until the compressed vector completes. It sits between the per-channel spectrum buffers and the cs_encoder.

Parameters:
NUM_CH, 4, number of requesting channels (2..8)
DATA_WIDTH, 16, I/Q component width; channel beat = 2*DATA_WIDTH
LFSR_WIDTH, 32, encoder seed width
INPUT_SIZE, 1024, samples per frame; length-check reference
FRAME_CNT_W, 16, width of per-frame counter used in seed derivation

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
ch_tdata  in  NUM_CH*2*DATA_WIDTH  per-channel samples {Q,I}, channel k at slice k
ch_tvalid  in  NUM_CH  per-channel valid; a channel requests service when tvalid=1
ch_tlast  in  NUM_CH  per-channel end of frame
ch_tready  out  NUM_CH  per-channel ready; only the granted bit can be 1
ch_ratio  in  NUM_CH*4  per-channel compression ratio
ch_seed  in  NUM_CH*LFSR_WIDTH  per-channel base seed
enc_s_tdata  out  2*DATA_WIDTH  to encoder s_axis_tdata
enc_s_tvalid  out  1  to encoder s_axis_tvalid
enc_s_tlast  out  1  to encoder s_axis_tlast
enc_s_tready  in  1  from encoder s_axis_tready
enc_m_tvalid  in  1  encoder m_axis_tvalid (monitor tap)
enc_m_tlast  in  1  encoder m_axis_tlast (monitor tap)
enc_m_tready  in  1  downstream m_axis_tready (monitor tap)
enc_cfg_ratio  out  4  to cfg_compress_ratio
enc_cfg_seed  out  LFSR_WIDTH  to cfg_lfsr_seed
enc_cfg_enable  out  1  to cfg_enable
enc_busy  in  1  encoder busy
grant  out  NUM_CH  one-hot active grant; 0 when idle
frame_done  out  1  one-cycle pulse at end of a serviced frame
frame_ch  out  $clog2(NUM_CH)  channel of the last completed frame
len_err  out  1  sticky; set if an input frame length != INPUT_SIZE
ratio_err  out  1  sticky; set if a requested ratio is outside 2..10

Behaviour:
- Reset values: all outputs 0; rr pointer = 0; frame counters = 0; state = S_IDLE.
- States: S_IDLE, S_CFG, S_STREAM, S_DRAIN, S_DONE.
- S_IDLE:
  - Wait until enc_busy=0.
  - Pick the first channel with ch_tvalid=1, searching from rr_ptr upward with wrap. No request means stay in S_IDLE.
  - On a pick: latch sel; grant[sel]=1 from the next cycle; latch ratio and seed; go to S_CFG.
- Ratio latch: value is 2..10 passes unchanged. Any other value is replaced by 4 and sets ratio_err.
- Seed latch: seed = ch_seed[sel] XOR zero-extended frame_cnt[sel]. If the result is 0, use 32'h1.
- enc_cfg_ratio and enc_cfg_seed hold the latched values from S_CFG through S_DONE. They are unchanged at all other times.
- enc_cfg_enable: 1 in S_CFG, S_STREAM and S_DRAIN; otherwise 0.
- S_CFG: lasts 1 cycle, then go to S_STREAM.
- S_STREAM:
  - enc_s_tdata/tvalid/tlast = selected channel's signals. ch_tready[sel] = enc_s_tready. All other ready bits are 0.
  - Combinational pass-through, zero latency.
  - Count beats on enc_s_tvalid & enc_s_tready.
  - On a handshake with tlast=1 or count=INPUT_SIZE: if count != INPUT_SIZE, set len_err. Then go to S_DRAIN.
- S_DRAIN:
  - enc_s_tvalid=0; all ch_tready=0.
  - Go to S_DONE on enc_m_tvalid & enc_m_tready & enc_m_tlast.
- S_DONE:
  - frame_done=1 for one cycle; frame_ch=sel (held until the next completion).
  - frame_cnt[sel] increments and wraps.
  - rr_ptr = sel+1 mod NUM_CH.
  - grant cleared; go to S_IDLE.
- Fairness: a channel that completes a frame has lowest priority in the next arbitration. With all channels requesting continuously, grants rotate 0,1,..,NUM_CH-1.
- ch_tvalid dropping mid-frame: stay in S_STREAM; no timeout unless the optional feature is enabled.
- Reset asserted mid-frame: all state returns to reset values immediately. Partial frames are discarded; the encoder must be reset by the same rst domain.
- ratio_err and len_err: cleared only by rst.

Optional Feature:
CS_SCHED_TIMEOUT_EN
- When defined: a 16-bit watchdog runs in S_STREAM and S_DRAIN, cleared on every input or output handshake.
  - On reaching 16'hFFFF: set sticky output timeout_err; drop enc_cfg_enable; pulse frame_done (frame_ch = sel); go to S_IDLE once enc_busy=0.
  - The timed-out channel's frame_cnt is not incremented.
- When undefined: no watchdog and no timeout_err port. S_STREAM and S_DRAIN wait indefinitely.

Test Plan:
- Single channel 0, ratio 4, seed 0xDEADBEEF, 1024 beats with tlast on beat 1024, downstream ready=1:
  - grant=0001; enc_cfg_seed=0xDEADBEEF; 256 encoder outputs; one frame_done with frame_ch=0; errors 0.
  - Second frame: seed 0xDEADBEEE (frame_cnt=1).
- All 4 channels requesting continuously, 3 frames each:
  - Grant order 0,1,2,3,0,1,2,3,0,1,2,3; grant never has more than one bit set; non-granted ch_tready always 0.
- Channel 2 with ratio 12:
  - enc_cfg_ratio=4; ratio_err=1; frame completes normally.
- Channel 1 sends tlast on beat 1000:
  - len_err=1; state S_DRAIN after beat 1000; frame_done follows encoder tlast.
- rst pulsed mid-S_STREAM at beat 500:
  - All outputs 0 the cycle after rst rises; a new frame after release starts from rr_ptr=0 with frame_cnt=0.
- CS_SCHED_TIMEOUT_EN defined; channel 3 stalls tvalid after beat 10 for 70000 cycles:
  - timeout_err=1 after 65535 idle cycles; frame_done pulse with frame_ch=3; return to S_IDLE.
